// File: rtl/procyon_ccu_pkg.sv
// Shared types and helpers for the Procyon cache coherence unit bus master.
// Transfer length codes follow the PCYN_CCU_LEN encoding: bytes = 2**code.
package procyon_ccu_pkg;

  localparam int CCU_LEN_WIDTH = 3;

  localparam logic [CCU_LEN_WIDTH-1:0] PCYN_CCU_LEN_1B   = 3'd0;
  localparam logic [CCU_LEN_WIDTH-1:0] PCYN_CCU_LEN_2B   = 3'd1;
  localparam logic [CCU_LEN_WIDTH-1:0] PCYN_CCU_LEN_4B   = 3'd2;
  localparam logic [CCU_LEN_WIDTH-1:0] PCYN_CCU_LEN_8B   = 3'd3;
  localparam logic [CCU_LEN_WIDTH-1:0] PCYN_CCU_LEN_16B  = 3'd4;
  localparam logic [CCU_LEN_WIDTH-1:0] PCYN_CCU_LEN_32B  = 3'd5;
  localparam logic [CCU_LEN_WIDTH-1:0] PCYN_CCU_LEN_64B  = 3'd6;
  localparam logic [CCU_LEN_WIDTH-1:0] PCYN_CCU_LEN_128B = 3'd7;

  typedef enum logic [1:0] {
    CCU_IDLE = 2'd0,
    CCU_XFER = 2'd1,
    CCU_DONE = 2'd2
  } ccu_state_e;

  function automatic logic [7:0] ccu_len_to_bytes(input logic [CCU_LEN_WIDTH-1:0] len);
    logic [7:0] bytes;
    case (len)
      PCYN_CCU_LEN_1B:   bytes = 8'd1;
      PCYN_CCU_LEN_2B:   bytes = 8'd2;
      PCYN_CCU_LEN_4B:   bytes = 8'd4;
      PCYN_CCU_LEN_8B:   bytes = 8'd8;
      PCYN_CCU_LEN_16B:  bytes = 8'd16;
      PCYN_CCU_LEN_32B:  bytes = 8'd32;
      PCYN_CCU_LEN_64B:  bytes = 8'd64;
      PCYN_CCU_LEN_128B: bytes = 8'd128;
      default:           bytes = 8'd4;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/procyon_priority_picker.sv
// Fixed-priority picker: lowest-index asserted request wins.
module procyon_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan from the highest index down so the lowest asserted index is the last writer
  always_comb begin
    o_grant = {NUM_REQ{1'b0}};
    o_idx   = {IDX_W{1'b0}};
    o_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_grant    = {NUM_REQ{1'b0}};
        o_grant[i] = 1'b1;
        o_idx      = IDX_W'(i);
        o_valid    = 1'b1;
      end else begin
        o_grant = o_grant;
        o_idx   = o_idx;
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/procyon_ccu_bus_master.sv
// CCU bus master: picks one VQ/MHQ line request and serialises it into word beats,
// returning a single-cycle grant (with the assembled line for reads) on completion.
module procyon_ccu_bus_master
  import procyon_ccu_pkg::*;
#(
  parameter int OPTN_ADDR_WIDTH     = 32,
  parameter int OPTN_DC_LINE_SIZE   = 32,
  parameter int OPTN_BUS_DATA_WIDTH = 32,
  parameter int OPTN_CCU_NUM_REQ    = 2,
  parameter int DC_LINE_WIDTH       = OPTN_DC_LINE_SIZE * 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [OPTN_CCU_NUM_REQ-1:0]                 i_ccu_en,
  input  logic [OPTN_CCU_NUM_REQ-1:0]                 i_ccu_we,
  input  logic [OPTN_CCU_NUM_REQ*CCU_LEN_WIDTH-1:0]   i_ccu_len,
  input  logic [OPTN_CCU_NUM_REQ*OPTN_ADDR_WIDTH-1:0] i_ccu_addr,
  input  logic [OPTN_CCU_NUM_REQ*DC_LINE_WIDTH-1:0]   i_ccu_data,
  output logic [OPTN_CCU_NUM_REQ-1:0]                 o_ccu_grant,
  output logic [DC_LINE_WIDTH-1:0]                    o_ccu_data,
  output logic                                        o_bus_req,
  output logic                                        o_bus_we,
  output logic [OPTN_ADDR_WIDTH-1:0]                  o_bus_addr,
  output logic [OPTN_BUS_DATA_WIDTH-1:0]              o_bus_wdata,
  input  logic                                        i_bus_ack,
  input  logic [OPTN_BUS_DATA_WIDTH-1:0]              i_bus_rdata
);

  localparam int BUS_BYTES = OPTN_BUS_DATA_WIDTH / 8;
  localparam int NUM_BEATS = OPTN_DC_LINE_SIZE / BUS_BYTES;
  localparam int BEAT_W    = $clog2(NUM_BEATS) + 1;
  localparam int IDX_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int REQ_W     = (OPTN_CCU_NUM_REQ > 1) ? $clog2(OPTN_CCU_NUM_REQ) : 1;
  localparam int BW        = OPTN_BUS_DATA_WIDTH;
  localparam int AW        = OPTN_ADDR_WIDTH;

  localparam logic [31:0]   LINE_BYTES_C = 32'(OPTN_DC_LINE_SIZE);
  localparam logic [31:0]   BUS_BYTES_C  = 32'(BUS_BYTES);
  localparam logic [AW-1:0] ADDR_STEP_C  = AW'(BUS_BYTES);

  ccu_state_e state_r;
  ccu_state_e state_s;

  logic [REQ_W-1:0]            idx_r;
  logic                        we_r;
  logic [BEAT_W-1:0]           beats_r;
  logic [BEAT_W-1:0]           beat_r;
  logic [BW-1:0]               line_r [NUM_BEATS];
  logic                        bus_req_r;
  logic                        bus_we_r;
  logic [AW-1:0]               bus_addr_r;
  logic [BW-1:0]               bus_wdata_r;
  logic [OPTN_CCU_NUM_REQ-1:0] grant_r;

  logic [OPTN_CCU_NUM_REQ-1:0] pick_grant_s;
  logic [REQ_W-1:0]            pick_idx_s;
  logic                        pick_valid_s;
  logic                        sel_we_s;
  logic [CCU_LEN_WIDTH-1:0]    sel_len_s;
  logic [AW-1:0]               sel_addr_s;
  logic [DC_LINE_WIDTH-1:0]    sel_data_s;
  logic [31:0]                 bytes_s;
  logic [31:0]                 clamp_s;
  logic [BEAT_W-1:0]           beats_s;
  logic [BEAT_W-1:0]           beat_nxt_s;
  logic                        last_beat_s;
  logic [OPTN_CCU_NUM_REQ-1:0] grant_onehot_s;
  logic [DC_LINE_WIDTH-1:0]    line_flat_s;

  procyon_priority_picker #(
    .NUM_REQ (OPTN_CCU_NUM_REQ),
    .IDX_W   (REQ_W)
  ) u_picker (
    .i_req   (i_ccu_en),
    .o_grant (pick_grant_s),
    .o_idx   (pick_idx_s),
    .o_valid (pick_valid_s)
  );

  // AND-OR mux of the picked requester's fields
  always_comb begin
    sel_we_s   = 1'b0;
    sel_len_s  = {CCU_LEN_WIDTH{1'b0}};
    sel_addr_s = {AW{1'b0}};
    sel_data_s = {DC_LINE_WIDTH{1'b0}};
    for (int i = 0; i < OPTN_CCU_NUM_REQ; i++) begin
      sel_we_s   = sel_we_s | (i_ccu_we[i] & pick_grant_s[i]);
      sel_len_s  = sel_len_s | (i_ccu_len[i*CCU_LEN_WIDTH +: CCU_LEN_WIDTH] & {CCU_LEN_WIDTH{pick_grant_s[i]}});
      sel_addr_s = sel_addr_s | (i_ccu_addr[i*AW +: AW] & {AW{pick_grant_s[i]}});
      sel_data_s = sel_data_s | (i_ccu_data[i*DC_LINE_WIDTH +: DC_LINE_WIDTH] & {DC_LINE_WIDTH{pick_grant_s[i]}});
    end
  end

  // Beat count: oversize lengths clamp to a line, narrow ones still move one full word
  always_comb begin
    bytes_s = 32'(ccu_len_to_bytes(sel_len_s));
    if (bytes_s > LINE_BYTES_C) begin
      clamp_s = LINE_BYTES_C;
    end else begin
      clamp_s = bytes_s;
    end
    if (clamp_s < BUS_BYTES_C) begin
      beats_s = BEAT_W'(1);
    end else begin
      beats_s = BEAT_W'(clamp_s / BUS_BYTES_C);
    end
  end

  assign beat_nxt_s  = beat_r + BEAT_W'(1);
  assign last_beat_s = (beat_nxt_s == beats_r);

  // Grant vector and flattened line view
  always_comb begin
    grant_onehot_s = {OPTN_CCU_NUM_REQ{1'b0}};
    line_flat_s    = {DC_LINE_WIDTH{1'b0}};
    for (int i = 0; i < OPTN_CCU_NUM_REQ; i++) begin
      grant_onehot_s[i] = (32'(idx_r) == 32'(i));
    end
    for (int i = 0; i < NUM_BEATS; i++) begin
      line_flat_s[i*BW +: BW] = line_r[i];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CCU_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      CCU_IDLE: begin
        if (pick_valid_s) begin
          state_s = CCU_XFER;
        end else begin
          state_s = CCU_IDLE;
        end
      end
      CCU_XFER: begin
        if (i_bus_ack && last_beat_s) begin
          state_s = CCU_DONE;
        end else begin
          state_s = CCU_XFER;
        end
      end
      CCU_DONE: state_s = CCU_IDLE;
      default:  state_s = CCU_IDLE;
    endcase
  end

  // Datapath: latch the request, step beats on ack, raise the grant on the last ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r       <= {REQ_W{1'b0}};
      we_r        <= 1'b0;
      beats_r     <= {BEAT_W{1'b0}};
      beat_r      <= {BEAT_W{1'b0}};
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_addr_r  <= {AW{1'b0}};
      bus_wdata_r <= {BW{1'b0}};
      grant_r     <= {OPTN_CCU_NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_BEATS; i++) begin
        line_r[i] <= {BW{1'b0}};
      end
    end else begin
      case (state_r)
        CCU_IDLE: begin
          if (pick_valid_s) begin
            idx_r      <= pick_idx_s;
            we_r       <= sel_we_s;
            beats_r    <= beats_s;
            beat_r     <= {BEAT_W{1'b0}};
            bus_req_r  <= 1'b1;
            bus_we_r   <= sel_we_s;
            bus_addr_r <= sel_addr_s;
            // Reads start from a zeroed line so bytes past a short transfer read back as 0
            for (int i = 0; i < NUM_BEATS; i++) begin
              line_r[i] <= sel_we_s ? sel_data_s[i*BW +: BW] : {BW{1'b0}};
            end
            bus_wdata_r <= sel_we_s ? sel_data_s[BW-1:0] : {BW{1'b0}};
          end
        end
        CCU_XFER: begin
          if (i_bus_ack) begin
            if (!we_r) begin
              line_r[beat_r[IDX_W-1:0]] <= i_bus_rdata;
            end
            beat_r <= beat_nxt_s;
            if (last_beat_s) begin
              bus_req_r   <= 1'b0;
              bus_we_r    <= 1'b0;
              bus_addr_r  <= {AW{1'b0}};
              bus_wdata_r <= {BW{1'b0}};
              grant_r     <= grant_onehot_s;
            end else begin
              bus_addr_r  <= bus_addr_r + ADDR_STEP_C;
              bus_wdata_r <= line_r[beat_nxt_s[IDX_W-1:0]];
            end
          end
        end
        CCU_DONE: begin
          grant_r <= {OPTN_CCU_NUM_REQ{1'b0}};
          beat_r  <= {BEAT_W{1'b0}};
        end
        default: begin
          grant_r   <= {OPTN_CCU_NUM_REQ{1'b0}};
          bus_req_r <= 1'b0;
          bus_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_ccu_grant = grant_r;
  assign o_ccu_data  = ((|grant_r) && !we_r) ? line_flat_s : {DC_LINE_WIDTH{1'b0}};
  assign o_bus_req   = bus_req_r;
  assign o_bus_we    = bus_we_r;
  assign o_bus_addr  = bus_addr_r;
  assign o_bus_wdata = bus_wdata_r;

endmodule

// File: tb/tb_procyon_ccu_bus_master.sv
// Self-checking bench for procyon_ccu_bus_master: word-bus memory responder plus a
// transaction-level reference model of expected beats, grants and read lines.
module tb_procyon_ccu_bus_master;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   en;
  logic [1:0]   we;
  logic [5:0]   len;
  logic [63:0]  addr;
  logic [511:0] data;
  logic [1:0]   grant;
  logic [255:0] ccu_data;
  logic         bus_req;
  logic         bus_we;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_ack;
  logic [31:0]  bus_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] log_addr  [$];
  logic [31:0] log_wdata [$];
  logic        log_we    [$];
  int          wait_cfg  = 0;
  int          wait_left = 0;
  bit          spurious  = 1'b0;

  bit           p_we   [2];
  logic [2:0]   p_len  [2];
  logic [31:0]  p_addr [2];
  logic [255:0] p_data [2];

  procyon_ccu_bus_master dut (
    .clk         (clk),
    .rst         (rst),
    .i_ccu_en    (en),
    .i_ccu_we    (we),
    .i_ccu_len   (len),
    .i_ccu_addr  (addr),
    .i_ccu_data  (data),
    .o_ccu_grant (grant),
    .o_ccu_data  (ccu_data),
    .o_bus_req   (bus_req),
    .o_bus_we    (bus_we),
    .o_bus_addr  (bus_addr),
    .o_bus_wdata (bus_wdata),
    .i_bus_ack   (bus_ack),
    .i_bus_rdata (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    if (slave_mem.exists(a)) return slave_mem[a];
    else return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    else return a ^ 32'hC0DE_0000;
  endfunction

  // Length code c means 2**c bytes; a 32-byte line over a 4-byte bus
  function automatic int nbeats_of(input logic [2:0] l);
    int b;
    b = 1 << l;
    if (b > 32) b = 32;
    if (b < 4) return 1;
    return b / 4;
  endfunction

  // Bus slave: ack after a configurable number of wait cycles, log every accepted beat
  initial begin
    bus_ack   = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst && bus_req) begin
        if (wait_left == 0) begin
          bus_ack   = 1'b1;
          bus_rdata = slave_rd(bus_addr);
          log_addr.push_back(bus_addr);
          log_we.push_back(bus_we);
          log_wdata.push_back(bus_wdata);
          if (bus_we) slave_mem[bus_addr] = bus_wdata;
          wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
        end else begin
          bus_ack = 1'b0;
          wait_left--;
        end
      end else begin
        bus_ack   = spurious && ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_wdata.delete();
  endtask

  task automatic post(input int r, input bit w, input logic [2:0] l,
                      input logic [31:0] a, input logic [255:0] d);
    p_we[r]   = w;
    p_len[r]  = l;
    p_addr[r] = a;
    p_data[r] = d;
    we[r]                = w;
    len[r*3 +: 3]        = l;
    addr[r*32 +: 32]     = a;
    data[r*256 +: 256]   = d;
    en[r]                = 1'b1;
  endtask

  // Run until every posted request is granted; the granted requester drops en one cycle late
  task automatic serve_all(input int exp_lat);
    int edges;
    bit first;
    edges = 0;
    first = 1'b1;
    while (en != 2'b00 && edges < 400) begin
      @(posedge clk);
      #1;
      edges++;
      check_val("grant_onehot0", 256'($onehot0(grant)), 256'd1);
      if (grant != 2'b00) begin
        int r;
        int nb;
        logic [1:0]   exp_g;
        logic [255:0] exp_line;
        r        = en[0] ? 0 : 1;
        nb       = nbeats_of(p_len[r]);
        exp_g    = 2'b00;
        exp_g[r] = 1'b1;
        exp_line = 256'h0;
        check_val("grant_idx", 256'(grant), 256'(exp_g));
        if (first && exp_lat >= 0) check_val("latency", 256'(edges + 1), 256'(exp_lat));
        first = 1'b0;
        check_val("beat_count", 256'(log_addr.size()), 256'(nb));
        for (int k = 0; k < nb && k < log_addr.size(); k++) begin
          check_val("beat_addr", 256'(log_addr[k]), 256'(p_addr[r] + 32'(4 * k)));
          check_val("beat_we", 256'(log_we[k]), 256'(p_we[r]));
          if (p_we[r]) check_val("beat_wdata", 256'(log_wdata[k]), 256'(p_data[r][k*32 +: 32]));
        end
        if (p_we[r]) begin
          for (int k = 0; k < nb; k++) ref_mem[p_addr[r] + 32'(4 * k)] = p_data[r][k*32 +: 32];
          check_val("write_data_zero", ccu_data, 256'h0);
        end else begin
          for (int k = 0; k < nb; k++) exp_line[k*32 +: 32] = ref_rd(p_addr[r] + 32'(4 * k));
          check_val("read_line", ccu_data, exp_line);
        end
        clear_log();
        @(posedge clk);
        #1;
        edges++;
        check_val("grant_pulse", 256'(grant), 256'h0);
        en[r] = 1'b0;
      end
    end
    if (en != 2'b00) begin
      check_val("timeout", 256'd1, 256'd0);
      en = 2'b00;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      check_val("idle_no_req", 256'(bus_req), 256'h0);
    end
  endtask

  initial begin
    logic [255:0] d;
    rst  = 1'b1;
    en   = 2'b00;
    we   = 2'b00;
    len  = 6'h0;
    addr = 64'h0;
    data = 512'h0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_grant", 256'(grant), 256'h0);
    check_val("rst_bus_req", 256'(bus_req), 256'h0);
    check_val("rst_bus_we", 256'(bus_we), 256'h0);
    check_val("rst_bus_addr", 256'(bus_addr), 256'h0);
    check_val("rst_bus_wdata", 256'(bus_wdata), 256'h0);
    check_val("rst_ccu_data", ccu_data, 256'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Requester 0 writes a full line at 0x100, zero-wait bus
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'h1111_0000 + 32'(k);
    wait_cfg = 0; wait_left = 0;
    post(0, 1'b1, 3'd5, 32'h0000_0100, d);
    serve_all(10);

    // Requester 1 reads 0x2000 with two wait cycles per beat
    for (int k = 0; k < 8; k++) begin
      slave_mem[32'h2000 + 32'(4 * k)] = 32'hA0 + 32'(k);
      ref_mem[32'h2000 + 32'(4 * k)]   = 32'hA0 + 32'(k);
    end
    wait_cfg = 2; wait_left = 2;
    post(1, 1'b0, 3'd5, 32'h0000_2000, 256'h0);
    serve_all(-1);

    // Both at once: req0 writes 0x400, then req1 must read back what req0 wrote
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
    wait_cfg = 0; wait_left = 0;
    post(0, 1'b1, 3'd5, 32'h0000_0400, d);
    post(1, 1'b0, 3'd5, 32'h0000_0400, 256'h0);
    serve_all(-1);

    // 4-byte read is one beat; the rest of the line reads as zero
    slave_mem[32'h500] = 32'hDEAD_BEEF;
    ref_mem[32'h500]   = 32'hDEAD_BEEF;
    post(0, 1'b0, 3'd2, 32'h0000_0500, 256'h0);
    serve_all(3);

    // Reset during beat 2 of an 8-beat read; the held request restarts from beat 0
    post(0, 1'b0, 3'd5, 32'h0000_0300, 256'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check_val("pre_rst_addr", 256'(bus_addr), 256'h308);
    rst = 1'b1;
    #1;
    check_val("midrst_bus_req", 256'(bus_req), 256'h0);
    check_val("midrst_grant", 256'(grant), 256'h0);
    check_val("midrst_bus_addr", 256'(bus_addr), 256'h0);
    clear_log();
    @(negedge clk);
    @(negedge clk);
    check_val("inrst_grant", 256'(grant), 256'h0);
    rst = 1'b0;
    clear_log();
    wait_left = 0;
    serve_all(10);

    // Randomised mix with random wait states and stray acks while the bus is idle
    wait_cfg = -1;
    spurious = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int mask;
      mask = int'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        if (mask[r]) begin
          for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
          post(r, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               32'h1000 + (32'($urandom_range(0, 15)) << 5), d);
        end
      end
      serve_all(-1);
    end
    spurious = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
